// File: rtl/serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_rx
// Brief    : XOR-parity serial frame receiver with a one-entry valid/ready
//            output register. Optional parity error counter enabled by
//            defining SERIAL_PARITY_RX_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_parity_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic [7:0]        err_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic             C_PAR_INV  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_rx_meta;
    logic              r_rx_s;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_pend;
    logic              r_frm_pend;
    logic              r_done;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_par_err;
    logic              r_frm_err;
    logic              r_overrun;

    // LSB-first shift: new bit enters at the top, works for DATA_W == 1 too
    logic [DATA_W:0]   w_shift_ext;
    logic [DATA_W-1:0] w_shift_next;
    assign w_shift_ext  = {r_rx_s, r_shift};
    assign w_shift_next = w_shift_ext[DATA_W:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par_pend <= 1'b0;
            r_frm_pend <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_done    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == C_CNT_HALF) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_CNT_FULL) begin
                        r_cnt   <= '0;
                        r_shift <= w_shift_next;
                        r_idx   <= r_idx + IDX_W'(1);
                        if (r_idx == C_IDX_LAST) r_state <= S_PARITY;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (r_cnt == C_CNT_FULL) begin
                        r_cnt      <= '0;
                        r_par_pend <= r_rx_s ^ (^r_shift) ^ C_PAR_INV;
                        r_state    <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == C_CNT_FULL) begin
                        r_cnt      <= '0;
                        r_frm_pend <= ~r_rx_s;
                        r_done     <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Output register: a completing frame may load in the same cycle it drains
            if (r_done) begin
                if (!r_valid || ready) begin
                    r_data    <= r_shift;
                    r_par_err <= r_par_pend;
                    r_frm_err <= r_frm_pend;
                    r_valid   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign valid      = r_valid;
    assign parity_err = r_par_err;
    assign frame_err  = r_frm_err;
    assign overrun    = r_overrun;

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Counts dropped frames too, since the error is judged at completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (r_done && r_par_pend && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
`default_nettype none
// Directed testbench for serial_parity_rx with default parameters.
module tb_serial_parity_rx;

    localparam int CPB = 16;
`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    localparam logic [7:0] C_ERR1 = 8'd1;
`else
    localparam logic [7:0] C_ERR1 = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       ready;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_start = 0;
    int rise_cyc = 0;
    int rise_cnt = 0;
    int rise_snap;
    logic prev_valid = 1'b0;

    serial_parity_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            rise_cyc = cyc;
            rise_cnt = rise_cnt + 1;
        end
        prev_valid = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        @(negedge clk);
        t_start = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = p;
        repeat (CPB) @(negedge clk);
        rx = s;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic accept(input string tag);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check(tag, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        rx    = 1'b1;
        ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",    {24'd0, data_out}, 32'h0);
        check("rst_valid",   {31'd0, valid}, 32'd0);
        check("rst_perr",    {31'd0, parity_err}, 32'd0);
        check("rst_ferr",    {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_errcnt",  {24'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean even-parity frame and latency
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_valid("a5_valid");
        check("a5_latency", rise_cyc - t_start, 32'd172);
        check("a5_data", {24'd0, data_out}, 32'hA5);
        check("a5_perr", {31'd0, parity_err}, 32'd0);
        check("a5_ferr", {31'd0, frame_err}, 32'd0);
        accept("a5_drop");

        // Parity error
        send_frame(8'h01, 1'b0, 1'b1);
        wait_valid("p01_valid");
        check("p01_data", {24'd0, data_out}, 32'h01);
        check("p01_perr", {31'd0, parity_err}, 32'd1);
        check("p01_errcnt", {24'd0, err_count}, {24'd0, C_ERR1});
        accept("p01_drop");

        // Glitch rejection then a good frame
        rise_snap = rise_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_norise", rise_cnt - rise_snap, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_valid("3c_valid");
        check("3c_data", {24'd0, data_out}, 32'h3C);
        check("3c_perr", {31'd0, parity_err}, 32'd0);
        accept("3c_drop");

        // Framing error
        send_frame(8'hFF, 1'b0, 1'b0);
        rx = 1'b1;
        wait_valid("ff_valid");
        check("ff_data", {24'd0, data_out}, 32'hFF);
        check("ff_ferr", {31'd0, frame_err}, 32'd1);
        check("ff_perr", {31'd0, parity_err}, 32'd0);
        repeat (30) @(negedge clk);
        check("ff_errcnt", {24'd0, err_count}, {24'd0, C_ERR1});
        accept("ff_drop");

        // Backpressure and overrun
        send_frame(8'h11, 1'b0, 1'b1);
        check("bp_ovr0", {31'd0, overrun}, 32'd0);
        send_frame(8'h22, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("bp_valid", {31'd0, valid}, 32'd1);
        check("bp_data", {24'd0, data_out}, 32'h11);
        check("bp_overrun", {31'd0, overrun}, 32'd1);
        accept("bp_drop");
        send_frame(8'h33, 1'b0, 1'b1);
        wait_valid("33_valid");
        check("33_data", {24'd0, data_out}, 32'h33);
        check("33_overrun", {31'd0, overrun}, 32'd1);
        accept("33_drop");

        // Reset in the middle of data bit 4 of 0x5A
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h5A >> i);
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_data",    {24'd0, data_out}, 32'h0);
        check("mrst_valid",   {31'd0, valid}, 32'd0);
        check("mrst_overrun", {31'd0, overrun}, 32'd0);
        check("mrst_errcnt",  {24'd0, err_count}, 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rise_snap = rise_cnt;
        repeat (200) @(negedge clk);
        check("mrst_norise", rise_cnt - rise_snap, 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_valid("5a_valid");
        check("5a_latency", rise_cyc - t_start, 32'd172);
        check("5a_data", {24'd0, data_out}, 32'h5A);
        check("5a_perr", {31'd0, parity_err}, 32'd0);
        check("5a_overrun", {31'd0, overrun}, 32'd0);
        accept("5a_drop");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
